ppc_seq_ctl: RTL

- Parametrised multicycle sequencer for the PPC core.
- Owns the PC, the latched instruction and the F/D/X/WB state machine, as the existing single-module core does.
- Adds req/ack handshakes to variable-latency instruction and data memories, a memory-wait state, sticky halt/fault states, a memory timeout, and cycle/retire counters.
- Decode, register file and ALU/branch logic stay outside and are driven from this block's strobes.

---
 rtl/ppc_seq_ctl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ppc_seq_ctl.sv
// ppc_seq_ctl: multicycle F/D/X/(M)/WB sequencer for the PPC core.
// Owns the PC, the latched instruction word, the memory handshakes, a
// memory-wait timeout and the cycle/retire counters. Decode, register file
// and ALU/branch logic live outside and follow this block's strobes.
//
// state   | meaning
// --------+---------------------------------------------------------------
// F  (0)  | fetch: imem_req high until imem_ack, instruction latched on ack
// D  (1)  | decode: rf_rd_en high, load/store flags latched
// X  (2)  | execute: single cycle, picks M for memory ops, else WB
// WB (3)  | commit: wb_en high, pc advances or branches, retire_cnt++
// M  (4)  | memory: dmem_req high until dmem_ack
// HALT(5) | sticky stop requested by the instruction; left only by reset
// FAULT(6)| sticky stop after a memory timeout; left only by reset
module ppc_seq_ctl #(
    parameter int unsigned     XLEN        = 64,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int unsigned     CNT_W       = 32,
    parameter int unsigned     MEM_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_data,
    output logic [31:0]      inst,
    output logic             rf_rd_en,
    input  logic             dec_mem_rd,
    input  logic             dec_mem_wr,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_target,
    input  logic             halt_req,
    output logic             wb_en,
    output logic [2:0]       state,
    output logic [XLEN-1:0]  pc,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        ST_F     = 3'd0,
        ST_D     = 3'd1,
        ST_X     = 3'd2,
        ST_WB    = 3'd3,
        ST_M     = 3'd4,
        ST_HALT  = 3'd5,
        ST_FAULT = 3'd6
    } state_t;

    localparam int unsigned WAIT_W = 32;
    localparam bit          TMO_EN = (MEM_TIMEOUT != 0);
    // The fault is taken in the unacked cycle whose increment would bring the
    // wait count up to the limit, so the compare is against limit-1.
    localparam logic [WAIT_W-1:0] TMO_LAST =
        TMO_EN ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  retire_q, retire_d;

    // Next-state, datapath updates and state-decoded strobes.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        wait_d   = wait_q;
        cycle_d  = cycle_q;
        retire_d = retire_q;
        imem_req = 1'b0;
        rf_rd_en = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        wb_en    = 1'b0;

        case (state_q)
            ST_F: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    inst_d  = imem_data;
                    state_d = ST_D;
                end else if (TMO_EN && (wait_q == TMO_LAST)) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_D: begin
                rf_rd_en = 1'b1;
                rd_d     = dec_mem_rd;
                wr_d     = dec_mem_wr;
                state_d  = ST_X;
            end
            ST_X: begin
                state_d = (rd_q || wr_q) ? ST_M : ST_WB;
            end
            ST_M: begin
                dmem_req = 1'b1;
                dmem_we  = wr_q;
                if (dmem_ack) begin
                    state_d = ST_WB;
                end else if (TMO_EN && (wait_q == TMO_LAST)) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_WB: begin
                wb_en    = 1'b1;
                pc_d     = br_taken ? (br_target & ~XLEN'(3)) : (pc_q + XLEN'(4));
                retire_d = retire_q + 1'b1;
                state_d  = halt_req ? ST_HALT : ST_F;
            end
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase

        if (state_q inside {ST_F, ST_D, ST_X, ST_WB, ST_M}) begin
            cycle_d = cycle_q + 1'b1;
        end
        if (state_d != state_q) begin
            wait_d = '0;
        end
    end

    // State register with synchronous reset; reset wins in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_F;
            pc_q     <= RESET_PC;
            inst_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            wait_q   <= '0;
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            wait_q   <= wait_d;
            cycle_q  <= cycle_d;
            retire_q <= retire_d;
        end
    end

    assign state      = state_q;
    assign pc         = pc_q;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign halted     = (state_q == ST_HALT);
    assign fault      = (state_q == ST_FAULT);
    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;

endmodule
